// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Definitions shared between the pixel capture stage and the frame buffer:
//   - fb_state_t        : capture FSM state encoding
//   - WE_ASSERT / WE_DEASSERT : levels of the buffer's active-low write strobe
//   - ACT_HIGH / ACT_LOW      : generic active-high assert constants
//   - PIX_WIDTH_DEF / PIX_PER_WORD_DEF : default pixel geometry
// ---------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } fb_state_t;

    localparam logic WE_ASSERT   = 1'b0;
    localparam logic WE_DEASSERT = 1'b1;
    localparam logic ACT_HIGH    = 1'b1;
    localparam logic ACT_LOW     = 1'b0;

    localparam int PIX_WIDTH_DEF    = 8;
    localparam int PIX_PER_WORD_DEF = 4;

endpackage

// File: rtl/pix_pack_wr_if.sv
// ---------------------------------------------------------------------------
// pix_pack_wr_if
// Pixel stream in / frame-buffer write bus out of the capture stage.
//   pix_valid, pix_data, sof, eof : pixel stream (driven by the source)
//   wr_en_l, data_out             : active-low write strobe and packed word
// Modports:
//   master : pixel source / write observer
//   slave  : the capture stage (pix_pack_wr)
// ---------------------------------------------------------------------------
interface pix_pack_wr_if
    import fb_pkg::*;
#(
    parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int DATA_WIDTH = PIX_WIDTH_DEF * PIX_PER_WORD_DEF
) ();

    logic                  pix_valid;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  sof;
    logic                  eof;
    logic                  wr_en_l;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output pix_valid, pix_data, sof, eof,
        input  wr_en_l, data_out
    );

    modport slave (
        input  pix_valid, pix_data, sof, eof,
        output wr_en_l, data_out
    );

endinterface

// File: rtl/pix_shift.sv
// ---------------------------------------------------------------------------
// pix_shift
// Packing register plus pixel index counter.
//   clk, reset : clock, synchronous active-high reset (index only)
//   clear      : empty the register, index back to 0
//   load0      : start a new word with pix_in in field 0 (upper fields zero)
//   append     : place pix_in at the current index; the register empties
//                itself when the word completes
//   pix_in     : incoming pixel
//   word_next  : the current word with pix_in inserted at the current index;
//                this is what gets written when a word is emitted
//   full       : pix_in would complete the word (index = PIX_PER_WORD-1)
// Fields above the current index are always zero, so a partially filled
// word_next is already zero-padded.
// ---------------------------------------------------------------------------
module pix_shift
    import fb_pkg::*;
#(
    parameter int PIX_WIDTH    = PIX_WIDTH_DEF,
    parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int DATA_WIDTH   = PIX_WIDTH * PIX_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load0,
    input  logic                  append,
    input  logic [PIX_WIDTH-1:0]  pix_in,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  full
);

    localparam int IDX_W = $clog2(PIX_PER_WORD);

    logic [DATA_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]      pix_idx;

    assign full = (pix_idx == IDX_W'(PIX_PER_WORD - 1));

    always_comb begin
        word_next = word_q;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (pix_idx == IDX_W'(i)) begin
                word_next[i*PIX_WIDTH +: PIX_WIDTH] = pix_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pix_idx <= '0;
        end else if (load0) begin
            pix_idx <= IDX_W'(1);
        end else if (append) begin
            pix_idx <= full ? '0 : pix_idx + IDX_W'(1);
        end
    end

    // The word register carries data only; every frame starts with load0,
    // which overwrites all fields, so it needs no reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            word_q <= '0;
        end else if (load0) begin
            word_q <= DATA_WIDTH'(pix_in);
        end else if (append) begin
            word_q <= full ? '0 : word_next;
        end
    end

endmodule

// File: rtl/pix_pack_wr.sv
// ---------------------------------------------------------------------------
// pix_pack_wr
// Capture stage in front of the frame buffer. Packs PIX_PER_WORD pixels of a
// sof/eof framed stream into DATA_WIDTH words (first pixel in the low field)
// and writes them with an active-low strobe, at most WORDS_PER_FRAME words
// per frame.
// Ports:
//   wr_clk     : capture/write clock
//   reset      : synchronous, active-high
//   cap_en     : level, enables capture of subsequent frames
//   bus        : pix_pack_wr_if.slave (pixel stream in, wr_en_l/data_out out)
//   busy       : high while capturing a frame
//   frame_done : one-cycle pulse when a frame ends
//   overrun    : sticky per frame (dropped word or aborted frame)
//   words_out  : number of words written for the last completed frame
// Build option:
//   PIX_PACK_FLUSH_EN : when defined, a partial word at eof is written
//                       zero-padded; otherwise it is discarded.
// ---------------------------------------------------------------------------
module pix_pack_wr
    import fb_pkg::*;
#(
    parameter int PIX_WIDTH       = PIX_WIDTH_DEF,
    parameter int PIX_PER_WORD    = PIX_PER_WORD_DEF,
    parameter int DATA_WIDTH      = PIX_WIDTH * PIX_PER_WORD,
    parameter int WORDS_PER_FRAME = 6,
    parameter int WCNT_WIDTH      = 16
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  cap_en,
    pix_pack_wr_if.slave          bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [WCNT_WIDTH-1:0] words_out
);

`ifdef PIX_PACK_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    fb_state_t             state, state_n;
    logic [WCNT_WIDTH-1:0] wcnt, wcnt_n;
    logic                  ovr_n;
    logic                  emit;
    logic                  word_ready;
    logic                  sh_clear, sh_load0, sh_append;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  word_full;
    logic                  pv;

    assign pv = bus.pix_valid;

    pix_shift #(
        .PIX_WIDTH    (PIX_WIDTH),
        .PIX_PER_WORD (PIX_PER_WORD),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_shift (
        .clk       (wr_clk),
        .reset     (reset),
        .clear     (sh_clear),
        .load0     (sh_load0),
        .append    (sh_append),
        .pix_in    (bus.pix_data),
        .word_next (word_next),
        .full      (word_full)
    );

    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        ovr_n      = overrun;
        emit       = 1'b0;
        word_ready = 1'b0;
        sh_clear   = 1'b0;
        sh_load0   = 1'b0;
        sh_append  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cap_en) state_n = ST_WAIT_SOF;
            end

            ST_WAIT_SOF: begin
                if (!cap_en) begin
                    state_n = ST_IDLE;
                end else if (pv && bus.sof) begin
                    state_n  = ST_CAPTURE;
                    sh_load0 = 1'b1;
                    wcnt_n   = '0;
                    ovr_n    = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (pv) begin
                    if (bus.eof) begin
                        // eof wins over a coincident sof. The eof pixel is
                        // taken from word_next, so the register just empties.
                        state_n    = ST_DONE;
                        sh_clear   = 1'b1;
                        word_ready = word_full || FLUSH_EN;
                    end else if (bus.sof) begin
                        // Restart: partial word lost, frame flagged as bad.
                        sh_load0 = 1'b1;
                        wcnt_n   = '0;
                        ovr_n    = 1'b1;
                    end else begin
                        sh_append  = 1'b1;
                        word_ready = word_full;
                    end
                end
                if (word_ready) begin
                    if (wcnt < WCNT_WIDTH'(WORDS_PER_FRAME)) begin
                        emit   = 1'b1;
                        wcnt_n = wcnt + WCNT_WIDTH'(1);
                    end else begin
                        ovr_n = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_n = cap_en ? ST_WAIT_SOF : ST_IDLE;
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            words_out  <= '0;
            bus.wr_en_l <= WE_DEASSERT;
            bus.data_out <= '0;
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            overrun     <= ovr_n;
            busy        <= (state_n == ST_CAPTURE);
            frame_done  <= (state_n == ST_DONE);
            bus.wr_en_l <= emit ? WE_ASSERT : WE_DEASSERT;
            if (state_n == ST_DONE) words_out <= wcnt_n;
            if (emit) bus.data_out <= word_next;
        end
    end

endmodule

// File: tb/tb_pix_pack_wr.sv
// ---------------------------------------------------------------------------
// tb_pix_pack_wr
// Directed bench for pix_pack_wr (PIX_WIDTH=8, PIX_PER_WORD=4,
// WORDS_PER_FRAME=6). A vector table covers a basic two-word frame; hand
// sequences cover overrun, partial words at eof, mid-frame sof, cap_en
// dropping mid-frame and reset in the middle of a word.
// Expectations for the partial-word case follow PIX_PACK_FLUSH_EN.
// ---------------------------------------------------------------------------
module tb_pix_pack_wr;

    logic        wr_clk;
    logic        reset;
    logic        cap_en;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_data[$];

    pix_pack_wr_if #(.PIX_WIDTH(8), .DATA_WIDTH(32)) bus ();

    pix_pack_wr #(
        .PIX_WIDTH       (8),
        .PIX_PER_WORD    (4),
        .DATA_WIDTH      (32),
        .WORDS_PER_FRAME (6),
        .WCNT_WIDTH      (16)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .cap_en     (cap_en),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .words_out  (words_out)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Record every write; the strobe is low for exactly one cycle per word.
    always @(negedge wr_clk) begin
        if (bus.wr_en_l === 1'b0) wr_data.push_back(bus.data_out);
    end

    typedef struct {
        logic        cap_en;
        logic        pv;
        logic        sof;
        logic        eof;
        logic [7:0]  pix;
        logic        we_l;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        ovr;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [7:0] p, input logic s, input logic e);
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        bus.sof       = s;
        bus.eof       = e;
        @(posedge wr_clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wr_en_l"},    32'(bus.wr_en_l),  32'h1);
        chk({tag, " data_out"},   bus.data_out,      32'h0);
        chk({tag, " busy"},       32'(busy),         32'h0);
        chk({tag, " frame_done"}, 32'(frame_done),   32'h0);
        chk({tag, " overrun"},    32'(overrun),      32'h0);
        chk({tag, " words_out"},  32'(words_out),    32'h0);
    endtask

    initial begin
        // Basic frame: sof + 0x01..0x08, eof on 0x08.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 32'h04030201, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 32'h04030201, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h06, 1'b1, 32'h04030201, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 32'h04030201, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b0, 32'h08070605, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h08070605, 1'b0, 1'b0, 1'b0, 16'd2};

        reset         = 1'b1;
        cap_en        = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
        idle(2);
        chk_reset_vals("reset");
        reset = 1'b0;

        // ---- table: basic two-word frame ----
        for (int i = 0; i < 10; i++) begin
            cap_en        = vecs[i].cap_en;
            bus.pix_valid = vecs[i].pv;
            bus.sof       = vecs[i].sof;
            bus.eof       = vecs[i].eof;
            bus.pix_data  = vecs[i].pix;
            @(posedge wr_clk);
            #1;
            chk($sformatf("v%0d wr_en_l", i),    32'(bus.wr_en_l), 32'(vecs[i].we_l));
            chk($sformatf("v%0d data_out", i),   bus.data_out,     vecs[i].data);
            chk($sformatf("v%0d busy", i),       32'(busy),        32'(vecs[i].busy));
            chk($sformatf("v%0d frame_done", i), 32'(frame_done),  32'(vecs[i].done));
            chk($sformatf("v%0d overrun", i),    32'(overrun),     32'(vecs[i].ovr));
            chk($sformatf("v%0d words_out", i),  32'(words_out),   32'(vecs[i].words));
        end
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.eof       = 1'b0;
        chk("basic write count", 32'(wr_data.size()), 32'd2);

        // ---- 28-pixel frame: 7 words, only 6 fit ----
        wr_data.delete();
        pix(8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 27; i++) pix(8'(i), 1'b0, 1'b0);
        pix(8'd27, 1'b0, 1'b1);
        chk("ovf frame_done", 32'(frame_done), 32'h1);
        chk("ovf words_out",  32'(words_out),  32'd6);
        chk("ovf overrun",    32'(overrun),    32'h1);
        idle(1);
        chk("ovf write count", 32'(wr_data.size()), 32'd6);
        if (wr_data.size() >= 6)
            chk("ovf last word", wr_data[5], 32'h17161514);
        pix(8'hA1, 1'b1, 1'b0);
        chk("ovf cleared by sof", 32'(overrun), 32'h0);
        pix(8'hA2, 1'b0, 1'b0);
        pix(8'hA3, 1'b0, 1'b0);
        pix(8'hA4, 1'b0, 1'b1);
        chk("after-ovf words_out", 32'(words_out), 32'd1);
        chk("after-ovf overrun",   32'(overrun),   32'h0);
        idle(1);

        // ---- 6-pixel frame: partial second word at eof ----
        wr_data.delete();
        pix(8'h11, 1'b1, 1'b0);
        pix(8'h12, 1'b0, 1'b0);
        pix(8'h13, 1'b0, 1'b0);
        pix(8'h14, 1'b0, 1'b0);
        pix(8'h15, 1'b0, 1'b0);
        pix(8'h16, 1'b0, 1'b1);
`ifdef PIX_PACK_FLUSH_EN
        chk("partial words_out", 32'(words_out), 32'd2);
        chk("partial wr_en_l",   32'(bus.wr_en_l), 32'h0);
        chk("partial data_out",  bus.data_out, 32'h00001615);
        idle(1);
        chk("partial write count", 32'(wr_data.size()), 32'd2);
`else
        chk("partial words_out", 32'(words_out), 32'd1);
        chk("partial wr_en_l",   32'(bus.wr_en_l), 32'h1);
        chk("partial data_out",  bus.data_out, 32'h14131211);
        idle(1);
        chk("partial write count", 32'(wr_data.size()), 32'd1);
`endif
        if (wr_data.size() >= 1)
            chk("partial first word", wr_data[0], 32'h14131211);

        // ---- sof after 2 pixels: abort and restart ----
        wr_data.delete();
        pix(8'h21, 1'b1, 1'b0);
        pix(8'h22, 1'b0, 1'b0);
        pix(8'h31, 1'b1, 1'b0);
        chk("abort overrun", 32'(overrun), 32'h1);
        chk("abort busy",    32'(busy),    32'h1);
        chk("abort wr_en_l", 32'(bus.wr_en_l), 32'h1);
        for (int i = 2; i <= 7; i++) pix(8'h30 + 8'(i), 1'b0, 1'b0);
        pix(8'h38, 1'b0, 1'b1);
        chk("abort words_out", 32'(words_out), 32'd2);
        chk("abort overrun at end", 32'(overrun), 32'h1);
        idle(1);
        chk("abort write count", 32'(wr_data.size()), 32'd2);
        if (wr_data.size() >= 2) begin
            chk("abort word0", wr_data[0], 32'h34333231);
            chk("abort word1", wr_data[1], 32'h38373635);
        end

        // ---- cap_en drops mid-frame ----
        wr_data.delete();
        pix(8'h41, 1'b1, 1'b0);
        pix(8'h42, 1'b0, 1'b0);
        cap_en = 1'b0;
        pix(8'h43, 1'b0, 1'b0);
        chk("capoff busy mid", 32'(busy), 32'h1);
        pix(8'h44, 1'b0, 1'b1);
        chk("capoff frame_done", 32'(frame_done), 32'h1);
        chk("capoff words_out",  32'(words_out),  32'd1);
        chk("capoff data_out",   bus.data_out,    32'h44434241);
        idle(1);
        chk("capoff idle busy", 32'(busy), 32'h0);
        pix(8'h71, 1'b1, 1'b0);
        pix(8'h72, 1'b0, 1'b0);
        pix(8'h73, 1'b0, 1'b0);
        pix(8'h74, 1'b0, 1'b1);
        chk("capoff ignored busy",       32'(busy),       32'h0);
        chk("capoff ignored frame_done", 32'(frame_done), 32'h0);
        idle(1);
        chk("capoff write count", 32'(wr_data.size()), 32'd1);
        chk("capoff words_out kept", 32'(words_out), 32'd1);

        // ---- reset after 3 pixels of a word ----
        wr_data.delete();
        cap_en = 1'b1;
        idle(1);
        pix(8'h51, 1'b1, 1'b0);
        pix(8'h52, 1'b0, 1'b0);
        pix(8'h53, 1'b0, 1'b0);
        reset         = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'h54;
        @(posedge wr_clk);
        #1;
        bus.pix_valid = 1'b0;
        chk_reset_vals("midword reset");
        reset = 1'b0;
        // Straight out of reset the FSM is IDLE, so this sof is ignored.
        pix(8'h61, 1'b1, 1'b0);
        chk("post-reset idle busy", 32'(busy), 32'h0);
        idle(1);
        chk("post-reset write count", 32'(wr_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_pack_wr.md
# pix_pack_wr

Upstream capture stage for the frame buffer. Accepts a pixel stream framed by start/end-of-frame strobes, packs `PIX_PER_WORD` pixels into one `DATA_WIDTH` word, and drives the buffer's active-low write enable and data bus, one word per write. It runs in the `wr_clk` domain. It limits each frame to `WORDS_PER_FRAME` writes and reports completion and overrun status.

## Interface
Parameters:
- `PIX_WIDTH`, 8, bits per pixel
- `PIX_PER_WORD`, 4, pixels packed per output word (≥2)
- `DATA_WIDTH`, `PIX_WIDTH*PIX_PER_WORD`, output word width; must equal the buffer `DATA_WIDTH`
- `WORDS_PER_FRAME`, 6, maximum writes per frame
- `WCNT_WIDTH`, 16, width of the word counter

Ports:
- `wr_clk`  in  1  capture/write clock
- `reset`  in  1  reset, synchronous, active-high; clock `wr_clk`
- `cap_en`  in  1  level; enables capture of subsequent frames
- `pix_valid`  in  1  pixel qualifier
- `pix_data`  in  `PIX_WIDTH`  pixel, sampled when `pix_valid`=1
- `sof`  in  1  start of frame; meaningful only with `pix_valid`=1, marks the first pixel
- `eof`  in  1  end of frame; meaningful only with `pix_valid`=1, marks the last pixel
- `wr_en_l`  out  1  active-low write strobe to the frame buffer
- `data_out`  out  `DATA_WIDTH`  packed word; valid while `wr_en_l`=0
- `busy`  out  1  high in CAPTURE
- `frame_done`  out  1  one-cycle pulse at frame end
- `overrun`  out  1  sticky per frame; cleared on the next accepted `sof`
- `words_out`  out  `WCNT_WIDTH`  word count of the last completed frame

## Operation
- All outputs are registered.
- Reset values: `wr_en_l`=1, `data_out`=0, `busy`=0, `frame_done`=0, `overrun`=0, `words_out`=0, and state=IDLE.
- Packing order: the first pixel of a word goes to bits `[PIX_WIDTH-1:0]`, the next pixel to the next field up, and so on.
- The pixel index counter `pix_idx` runs 0..`PIX_PER_WORD`-1 and wraps to 0 after each emitted word.

States:
- IDLE
  - Ignores all pixels.
  - `cap_en`=1 → WAIT_SOF.
- WAIT_SOF
  - `cap_en`=0 → IDLE.
  - `pix_valid`&`sof` → CAPTURE. That pixel is packed at index 0, the word count is cleared and `overrun` is cleared.
  - Pixels without `sof` are dropped.
- CAPTURE
  - Each valid pixel is packed.
  - When `pix_idx` reaches `PIX_PER_WORD`-1, the word is emitted if the word count < `WORDS_PER_FRAME`. Otherwise the word is dropped and `overrun`←1.
  - `pix_valid`&`eof` → DONE.
  - `pix_valid`&`sof` (without `eof`) → abort: the partial word is discarded, `overrun`←1, the word count is cleared, and the pixel is packed at index 0. The state stays CAPTURE and `overrun` stays set for the new frame.
  - `sof`&`eof` together on one pixel: treated as `eof`.
  - `cap_en` is not sampled in CAPTURE; the current frame always completes.
- DONE (one cycle)
  - `frame_done`=1 and `words_out`←final count.
  - `cap_en`=1 → WAIT_SOF, else → IDLE.
  - Pixels, including `sof`, are dropped in this cycle.
- Arithmetic: the word count saturates at `WORDS_PER_FRAME` and never wraps. `words_out` reports only emitted words, never dropped ones.

## Timing
- Word emission: the pixel completing a word is accepted at cycle N. At N+1, `wr_en_l`=0 for exactly one cycle and `data_out` = the word. `data_out` holds until the next emission.
- Frame end: an `eof` pixel at cycle N gives DONE at N+1, `frame_done`=1 at N+1 and `busy`=0 at N+1. Any word completed by the `eof` pixel is written at N+1.
- Back-to-back words are allowed: with `PIX_PER_WORD` valid pixels per word, the writes are spaced `PIX_PER_WORD` cycles apart.
- The minimum gap from `eof` to the next accepted `sof` is 2 cycles (DONE occupies one cycle).
- A `reset` at any cycle has effect at the next edge: the partial word is lost and no write is issued.

## Configuration
- `PIX_PACK_FLUSH_EN` defined:
  - An `eof` that leaves a partial word (`pix_idx` ≠ `PIX_PER_WORD`-1) emits that word at N+1.
  - The unfilled upper fields are zero.
  - The write is subject to the `WORDS_PER_FRAME` limit.
- Undefined:
  - The partial word is discarded.
  - No write is issued.
  - `words_out` excludes it.

## Structure
- Shared package `fb_pkg`:
  - the state encoding (IDLE, WAIT_SOF, CAPTURE, DONE)
  - the active-low/high assert constants shared with the frame buffer
  - the default `PIX_WIDTH`/`PIX_PER_WORD`
- Sub-module `pix_shift`: the packing register plus `pix_idx` counter, with controls clear, load-at-0, and append, and a "word full" flag.
- The FSM, word counter and status flags live in the top level.

## Test plan
- Reset, `cap_en`=1, then `sof` plus 8 pixels 0x01..0x08 with `eof` on 0x08 → two writes, `data_out`=0x04030201 then 0x08070605. `frame_done` one cycle after 0x08, `words_out`=2, `overrun`=0.
- Frame of 28 pixels with `WORDS_PER_FRAME`=6 → exactly 6 writes, `overrun`=1, `words_out`=6. Next `sof` clears `overrun`.
- Frame of 6 pixels 0x11..0x16 → with `PIX_PACK_FLUSH_EN`: writes 0x14131211 and 0x00001615, `words_out`=2. Without: one write, `words_out`=1.
- `sof` arrives after 2 pixels of a frame → no write of the partial word, `overrun`=1. The new frame packs from index 0.
- `cap_en` drops mid-frame → the frame completes with `frame_done`, then IDLE. A following `sof` produces no writes.
- `reset` asserted after 3 pixels of a word → `wr_en_l` stays 1, all outputs return to reset values, state IDLE.
